// File: rtl/adc_eth_packetizer.sv
// adc_eth_packetizer: buffers the non-stallable ADC byte stream in a byte FIFO and frames it
// into header / payload / XOR-checksum packets on a byte-wide valid/ready stream.
module adc_eth_packetizer #(
  parameter int FIFO_DEPTH  = 2048,
  parameter int PAYLOAD_LEN = 1024,
  parameter int IFG         = 12
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  input  logic        clear_ovf,
  output logic [15:0] seq_num
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] PLEN     = 16'(PAYLOAD_LEN);
  localparam logic [15:0] GAP_LAST = (IFG > 0) ? 16'(IFG - 1) : 16'd0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [2:0] i, input logic [15:0] seq);
    logic [7:0] b;
    b = PLEN[7:0];
    case (i)
      3'd0:    b = 8'hA5;
      3'd1:    b = 8'h5A;
      3'd2:    b = seq[15:8];
      3'd3:    b = seq[7:0];
      3'd4:    b = PLEN[15:8];
      default: b = PLEN[7:0];
    endcase
    return b;
  endfunction

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic          ld;
  logic          frame_go;
  logic [7:0]    rd_data;

  logic [2:0]    state;
  logic [15:0]   idx;
  logic [15:0]   gap_cnt;
  logic [7:0]    csum;

  // Full is judged on the pre-pop count, so a same-cycle read never makes room for a write.
  assign full     = (count == CW'(FIFO_DEPTH));
  assign push     = din_valid && !full;
  assign drop     = din_valid && full;
  assign ld       = !m_tvalid || m_tready;
  assign pop      = (state == S_PAY) && ld;
  assign rd_data  = mem[rd_ptr];
  assign frame_go = en && (32'(count) >= 32'(PAYLOAD_LEN));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= 16'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= sat_inc16(drop_cnt);
    end
  end

  // Output register is loaded whenever it is empty or being accepted; the state names
  // the kind of byte loaded next, so the stream runs without bubbles under full ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      idx      <= 16'd0;
      gap_cnt  <= 16'd0;
      csum     <= 8'h00;
      seq_num  <= 16'd0;
      m_tdata  <= 8'h00;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_go) begin
            m_tdata  <= hdr_byte(3'd0, seq_num);
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
            idx      <= 16'd1;
            csum     <= 8'h00;
            state    <= S_HDR;
          end
        end
        S_HDR: begin
          if (ld) begin
            m_tdata <= hdr_byte(idx[2:0], seq_num);
            if (idx == 16'd5) begin
              idx   <= 16'd0;
              state <= S_PAY;
            end else begin
              idx <= idx + 16'd1;
            end
          end
        end
        S_PAY: begin
          if (ld) begin
            m_tdata <= rd_data;
            csum    <= csum ^ rd_data;
            if (idx == PLEN - 16'd1) state <= S_CSUM;
            else                     idx   <= idx + 16'd1;
          end
        end
        S_CSUM: begin
          // m_tlast separates "checksum not yet loaded" from "checksum waiting for accept".
          if (ld) begin
            if (!m_tlast) begin
              m_tdata <= csum;
              m_tlast <= 1'b1;
            end else begin
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
              gap_cnt  <= 16'd0;
              state    <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt >= GAP_LAST) begin
            seq_num <= seq_num + 16'd1;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_eth_packetizer.sv
// Directed bench for adc_eth_packetizer with PAYLOAD_LEN=8, FIFO_DEPTH=16, IFG=2.
module tb_adc_eth_packetizer;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [7:0]  din;
  logic        din_valid;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        clear_ovf;
  logic [15:0] seq_num;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int fstamp = 0;
  int lstamp = 0;
  logic tog = 1'b0;

  logic [8:0] cap_q[$];
  int         stamp_q[$];

  adc_eth_packetizer #(
    .FIFO_DEPTH(16),
    .PAYLOAD_LEN(8),
    .IFG(2)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .en(en),
    .din(din),
    .din_valid(din_valid),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast(m_tlast),
    .overflow(overflow),
    .drop_cnt(drop_cnt),
    .clear_ovf(clear_ovf),
    .seq_num(seq_num)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transfer monitor and stall-stability check, sampled on the falling edge.
  initial begin
    logic       stall_prev;
    logic [7:0] prev_data;
    logic       prev_last;
    stall_prev = 1'b0;
    prev_data  = 8'h00;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rstn) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          total++;
          assert (m_tvalid === 1'b1 && m_tdata === prev_data && m_tlast === prev_last) else begin
            bad++;
            $error("FAIL stall_hold: observed=%0b/%02h/%0b expected=1/%02h/%0b",
                   m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
          end
        end
        if (m_tvalid && m_tready) begin
          cap_q.push_back({m_tlast, m_tdata});
          stamp_q.push_back(ncyc);
        end
        stall_prev = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (tog) m_tready = ~m_tready;
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      din       = first + 8'(i);
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
  endtask

  task automatic expect_frame(input string nm, input logic [15:0] s, input logic [7:0] first);
    logic [7:0] exp_b [15];
    logic [7:0] x;
    logic [8:0] got;
    int waited;
    int t;
    x = 8'h00;
    exp_b[0] = 8'hA5;
    exp_b[1] = 8'h5A;
    exp_b[2] = s[15:8];
    exp_b[3] = s[7:0];
    exp_b[4] = 8'h00;
    exp_b[5] = 8'h08;
    for (int i = 0; i < 8; i++) begin
      exp_b[6+i] = first + 8'(i);
      x = x ^ exp_b[6+i];
    end
    exp_b[14] = x;
    waited = 0;
    while (cap_q.size() < 15 && waited < 400) begin
      step();
      waited++;
    end
    if (cap_q.size() < 15) begin
      chk({nm, " timeout bytes"}, cap_q.size(), 15);
      cap_q.delete();
      stamp_q.delete();
    end else begin
      for (int i = 0; i < 15; i++) begin
        got = cap_q.pop_front();
        t   = stamp_q.pop_front();
        if (i == 0)  fstamp = t;
        if (i == 14) lstamp = t;
        chk($sformatf("%s byte%0d", nm, i), {23'b0, got}, {23'b0, (i == 14), exp_b[i]});
      end
    end
  endtask

  initial begin
    int hi;
    int waited;
    int f1_last;
    rstn      = 1'b0;
    en        = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    m_tready  = 1'b0;
    clear_ovf = 1'b0;
    repeat (3) step();

    chk("rst m_tvalid", m_tvalid, 0);
    chk("rst m_tlast", m_tlast, 0);
    chk("rst m_tdata", m_tdata, 8'h00);
    chk("rst overflow", overflow, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    chk("rst seq_num", seq_num, 0);
    rstn = 1'b1;
    step();

    // Scenario 1: one frame with ready held high.
    en = 1'b1;
    m_tready = 1'b1;
    push_seq(8'h01, 8);
    expect_frame("t1", 16'd0, 8'h01);
    repeat (5) step();
    chk("t1 seq_num", seq_num, 16'd1);
    chk("t1 idle tvalid", m_tvalid, 0);

    // Scenario 2: ready toggling every cycle.
    tog = 1'b1;
    push_seq(8'h01, 8);
    expect_frame("t2", 16'd1, 8'h01);
    tog = 1'b0;
    m_tready = 1'b1;
    repeat (5) step();
    chk("t2 seq_num", seq_num, 16'd2);

    // Scenario 3: two back-to-back frames.
    push_seq(8'h11, 16);
    expect_frame("t3a", 16'd2, 8'h11);
    f1_last = lstamp;
    expect_frame("t3b", 16'd3, 8'h19);
    chk("t3 ifg>=2", 32'((fstamp - f1_last - 1) >= 2), 1);
    repeat (5) step();

    // Scenario 4: overflow with en low, clear behaviour, then release.
    en = 1'b0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      din       = 8'h31 + 8'(i);
      din_valid = 1'b1;
      step();
      if (m_tvalid) hi++;
    end
    din_valid = 1'b0;
    step();
    if (m_tvalid) hi++;
    chk("t4 no tvalid", hi, 0);
    chk("t4 overflow", overflow, 1);
    chk("t4 drop_cnt", drop_cnt, 16'd4);
    din       = 8'hEE;
    din_valid = 1'b1;
    clear_ovf = 1'b1;
    step();
    din_valid = 1'b0;
    clear_ovf = 1'b0;
    chk("t4 clr+drop overflow", overflow, 0);
    chk("t4 clr+drop drop_cnt", drop_cnt, 16'd0);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk("t4 redrop overflow", overflow, 1);
    chk("t4 redrop drop_cnt", drop_cnt, 16'd1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("t4 clear overflow", overflow, 0);
    chk("t4 clear drop_cnt", drop_cnt, 16'd0);
    en = 1'b1;
    expect_frame("t4a", 16'd4, 8'h31);
    expect_frame("t4b", 16'd5, 8'h39);
    repeat (6) step();
    chk("t4 seq_num", seq_num, 16'd6);

    // Scenario 5: threshold exactly at PAYLOAD_LEN.
    push_seq(8'h51, 7);
    hi = 0;
    repeat (50) begin
      step();
      if (m_tvalid) hi++;
    end
    chk("t5 7 bytes no tvalid", hi, 0);
    din       = 8'h58;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    if (!m_tvalid) step();
    chk("t5 latency tvalid", m_tvalid, 1);
    expect_frame("t5", 16'd6, 8'h51);
    repeat (6) step();

    // Scenario 6: reset in the middle of the payload.
    push_seq(8'h61, 8);
    waited = 0;
    while (!(m_tvalid && m_tdata == 8'h63) && waited < 60) begin
      step();
      waited++;
    end
    chk("t6 reached payload3", 32'(m_tvalid && m_tdata == 8'h63), 1);
    rstn = 1'b0;
    #1;
    chk("t6 rst tvalid", m_tvalid, 0);
    chk("t6 rst tlast", m_tlast, 0);
    chk("t6 rst seq_num", seq_num, 16'd0);
    step();
    step();
    rstn = 1'b1;
    step();
    cap_q.delete();
    stamp_q.delete();
    hi = 0;
    repeat (10) begin
      step();
      if (m_tvalid) hi++;
    end
    chk("t6 no tail after reset", hi, 0);
    push_seq(8'h71, 8);
    expect_frame("t6", 16'd0, 8'h71);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_eth_packetizer.md
Name: adc_eth_packetizer

Overview:
- Consumes the 8-bit interleaved sample byte stream produced by the ADC buffering stage (dout/dout_valid, 125 MHz domain, no backpressure).
- Frames it into fixed-length packets for the Ethernet/UDP transmit path: 6-byte header, PAYLOAD_LEN payload bytes, 1-byte XOR checksum.
- Output is a byte-wide valid/ready stream with a last marker.
- Contains an internal byte FIFO that absorbs the non-stallable input while the MAC applies backpressure.

Parameters:
- FIFO_DEPTH, 2048: byte FIFO depth. Power of two, >= PAYLOAD_LEN.
- PAYLOAD_LEN, 1024: payload bytes per frame. Range 1..65535.
- IFG, 12: minimum idle cycles, tvalid low, between frames.

Ports:
- clk  in  1  sole clock (ADC buffer output clock).
- rstn  in  1  asynchronous active-low reset.
- en  in  1  frame-start enable. When low, no new frame starts; a frame in progress completes; input is still buffered.
- din  in  8  sample byte from the ADC buffer.
- din_valid  in  1  din qualifier. May be high every cycle; cannot be stalled.
- m_tdata  out  8  output byte.
- m_tvalid  out  1  output byte valid.
- m_tready  in  1  downstream accepts byte.
- m_tlast  out  1  high on the checksum byte.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- drop_cnt  out  16  dropped-byte count, saturates at 0xFFFF.
- clear_ovf  in  1  single-cycle pulse; clears overflow and drop_cnt.
- seq_num  out  16  sequence number of the next or current frame.

Behaviour:
- Reset values (asynchronous, rstn low):
  - m_tvalid=0, m_tlast=0, m_tdata=0x00.
  - overflow=0, drop_cnt=0, seq_num=0.
  - FIFO emptied; FSM in IDLE.
- Reset mid-frame abandons the frame. No partial tail is emitted after release.
- FIFO write:
  - din_valid=1 and FIFO not full -> byte stored.
  - Full -> byte discarded, overflow set, drop_cnt incremented.
  - A read in the same cycle does not free space for that write; full is evaluated on the pre-pop count.
- Fill count width: clog2(FIFO_DEPTH)+1. Simultaneous push and pop leaves the count unchanged.
- clear_ovf coincident with a drop: the clear wins. overflow=0, drop_cnt=0.
- FSM states: IDLE -> HDR -> PAY -> CSUM -> GAP -> IDLE.
  - IDLE: move to HDR when en=1 and fill count >= PAYLOAD_LEN. m_tvalid must rise within 2 cycles of that condition becoming true.
  - HDR: emit 6 bytes in order:
    - 0xA5, 0x5A.
    - seq_num[15:8], seq_num[7:0].
    - PAYLOAD_LEN[15:8], PAYLOAD_LEN[7:0].
  - PAY: emit exactly PAYLOAD_LEN bytes popped from the FIFO, in arrival order. A running XOR accumulates them; it is cleared on entry to HDR.
  - CSUM: emit the XOR of all payload bytes only, with m_tlast=1.
  - GAP: m_tvalid=0 for IFG cycles. On exit, seq_num increments, wrapping 0xFFFF -> 0x0000.
- Handshake:
  - A byte transfers when m_tvalid and m_tready are both high.
  - While m_tvalid=1 and m_tready=0, m_tdata and m_tlast hold stable.
  - m_tvalid never drops mid-frame.
- Throughput: with m_tready held high, one byte per cycle from the first header byte to the checksum, with no bubbles.
- Payload is guaranteed present at frame start, so no FIFO underflow is possible. en falling mid-frame has no effect on the current frame.

Test Plan (PAYLOAD_LEN=8, FIFO_DEPTH=16, IFG=2):
1. Reset, en=1, m_tready=1; push 0x01..0x08 -> 15 bytes: A5 5A 00 00 00 08 01 02 03 04 05 06 07 08 08. m_tlast only on the final byte (checksum 0x08). seq_num=1 after GAP.
2. Repeat scenario 1 with m_tready toggling 1/0 every cycle -> identical byte sequence; m_tdata/m_tlast stable on every stalled cycle.
3. Push 16 more bytes after scenario 1 -> two back-to-back frames carrying seq bytes 00 01 and 00 02. At least 2 tvalid-low cycles between them; payloads in push order.
4. en=0; push 20 bytes consecutively -> no m_tvalid, overflow=1, drop_cnt=4. Pulse clear_ovf -> both 0. Raise en -> a frame carries the first 8 stored bytes.
5. Push 7 bytes -> m_tvalid stays 0 for 50 cycles. Push the 8th byte -> m_tvalid high within 2 cycles.
6. Assert rstn low during payload byte 3 -> m_tvalid=0 immediately, seq_num=0, FIFO empty. Push 8 new bytes -> a complete frame with seq 00 00.
